// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg : shared state type, default timing constants, timer sizing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam int DEF_SNOOZE_SEC       = 300;
  localparam int DEF_RING_TIMEOUT_SEC = 60;
  localparam int DEF_MAX_SNOOZES      = 3;
  localparam int DEF_TONE_DIV         = 4;

  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_tone_gen.sv
// ---------------------------------------------------------------------------
// alarm_tone_gen : enable-gated square-wave divider, restarts low on enable rise
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_tone_gen #(
  parameter int TONE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_buzzer
);

  localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_en_d;
  logic          r_buzzer;

  // The enabling edge itself does not count toward the first half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_en_d   <= 1'b0;
      r_buzzer <= 1'b0;
    end else begin
      r_en_d <= i_en;
      if (!(i_en && r_en_d)) begin
        r_cnt    <= '0;
        r_buzzer <= 1'b0;
      end else if (r_cnt == CW'(TONE_DIV - 1)) begin
        r_cnt    <= '0;
        r_buzzer <= ~r_buzzer;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_buzzer = r_buzzer;

endmodule

`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ring_ctrl : ringing/snooze controller driving buzzer, flags and LED
// Rev 1.0   Optional macro: ALARM_LED_BLINK_EN (LED blinks per second while active)
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = DEF_SNOOZE_SEC,
  parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC,
  parameter int MAX_SNOOZES      = DEF_MAX_SNOOZES,
  parameter int TONE_DIV         = DEF_TONE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick_1hz,
  input  logic i_alarm_match,
  input  logic i_alarm_en,
  input  logic i_snooze_btn,
  input  logic i_stop_btn,
  output logic o_buzzer,
  output logic o_ringing,
  output logic o_snoozing,
  output logic o_missed,
  output logic o_led
);

  localparam int TW   = timer_width(SNOOZE_SEC, RING_TIMEOUT_SEC);
  localparam int CNTW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

  state_t            r_state;
  state_t            w_next_state;
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     w_next_timer;
  logic [CNTW-1:0]   r_snz_cnt;
  logic [CNTW-1:0]   w_next_cnt;
  logic              r_missed;
  logic              w_next_missed;
  logic              r_snooze_d;
  logic              r_stop_d;
  logic              w_snooze_edge;
  logic              w_stop_edge;

  assign w_snooze_edge = i_snooze_btn & ~r_snooze_d;
  assign w_stop_edge   = i_stop_btn & ~r_stop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_snz_cnt  <= '0;
      r_missed   <= 1'b0;
      r_snooze_d <= 1'b0;
      r_stop_d   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_timer    <= w_next_timer;
      r_snz_cnt  <= w_next_cnt;
      r_missed   <= w_next_missed;
      r_snooze_d <= i_snooze_btn;
      r_stop_d   <= i_stop_btn;
    end
  end

  // A single timer serves both states: it is zeroed on every state entry.
  always_comb begin
    w_next_state  = r_state;
    w_next_timer  = r_timer;
    w_next_cnt    = r_snz_cnt;
    w_next_missed = r_missed;
    case (r_state)
      ST_IDLE: begin
        if (w_stop_edge) begin
          w_next_missed = 1'b0;
        end else if (i_alarm_match && i_alarm_en) begin
          w_next_state  = ST_RINGING;
          w_next_timer  = '0;
          w_next_cnt    = '0;
          w_next_missed = 1'b0;
        end
      end
      ST_RINGING: begin
        if (!i_alarm_en || w_stop_edge) begin
          w_next_state = ST_IDLE;
          w_next_timer = '0;
        end else if (w_snooze_edge && (r_snz_cnt < CNTW'(MAX_SNOOZES))) begin
          w_next_state = ST_SNOOZE;
          w_next_timer = '0;
          w_next_cnt   = r_snz_cnt + 1'b1;
        end else if (i_tick_1hz) begin
          if (r_timer == TW'(RING_TIMEOUT_SEC - 1)) begin
            w_next_state  = ST_IDLE;
            w_next_timer  = '0;
            w_next_missed = 1'b1;
          end else begin
            w_next_timer = r_timer + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (!i_alarm_en || w_stop_edge) begin
          w_next_state = ST_IDLE;
          w_next_timer = '0;
        end else if (i_tick_1hz) begin
          if (r_timer == TW'(SNOOZE_SEC - 1)) begin
            w_next_state = ST_RINGING;
            w_next_timer = '0;
          end else begin
            w_next_timer = r_timer + 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_timer = '0;
      end
    endcase
  end

  // Driven from next state so the buzzer drops on the same edge the state leaves RINGING.
  alarm_tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_next_state == ST_RINGING),
    .o_buzzer (o_buzzer)
  );

  assign o_ringing  = (r_state == ST_RINGING);
  assign o_snoozing = (r_state == ST_SNOOZE);
  assign o_missed   = r_missed;

`ifdef ALARM_LED_BLINK_EN
  logic r_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= 1'b0;
    end else if (w_next_state == ST_IDLE) begin
      r_led <= 1'b0;
    end else if ((r_state != ST_IDLE) && i_tick_1hz) begin
      r_led <= ~r_led;
    end
  end

  assign o_led = r_led;
`else
  assign o_led = o_ringing | r_missed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_ring_ctrl : directed plus randomized bench against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alarm_ring_ctrl;

  localparam int SNOOZE_SEC       = 3;
  localparam int RING_TIMEOUT_SEC = 5;
  localparam int MAX_SNOOZES      = 3;
  localparam int TONE_DIV         = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, match = 1'b0, en = 1'b0, snz = 1'b0, stp = 1'b0;
  logic o_buzzer, o_ringing, o_snoozing, o_missed, o_led;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0=idle 1=ringing 2=snoozing
  int m_mode, m_secs, m_snoozes, m_ring_cycles;
  bit m_missed, m_led, m_prev_snz, m_prev_stp;

  always #5 clk = ~clk;

  alarm_ring_ctrl #(
    .SNOOZE_SEC       (SNOOZE_SEC),
    .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC),
    .MAX_SNOOZES      (MAX_SNOOZES),
    .TONE_DIV         (TONE_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_tick_1hz    (tick),
    .i_alarm_match (match),
    .i_alarm_en    (en),
    .i_snooze_btn  (snz),
    .i_stop_btn    (stp),
    .o_buzzer      (o_buzzer),
    .o_ringing     (o_ringing),
    .o_snoozing    (o_snoozing),
    .o_missed      (o_missed),
    .o_led         (o_led)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_snoozes = 0; m_ring_cycles = 0;
    m_missed = 0; m_led = 0; m_prev_snz = 0; m_prev_stp = 0;
  endtask

  task automatic model_update();
    bit stop_e, snz_e;
    int old_mode;
    stop_e = stp && !m_prev_stp;
    snz_e  = snz && !m_prev_snz;
    m_prev_stp = stp;
    m_prev_snz = snz;
    old_mode = m_mode;
    if (m_mode == 0) begin
      if (stop_e) m_missed = 0;
      else if (match && en) begin
        m_mode = 1; m_secs = 0; m_snoozes = 0; m_missed = 0; m_ring_cycles = 0;
      end
    end else if (m_mode == 1) begin
      if (!en || stop_e) m_mode = 0;
      else if (snz_e && m_snoozes < MAX_SNOOZES) begin
        m_mode = 2; m_snoozes++; m_secs = 0;
      end else if (tick) begin
        m_secs++;
        if (m_secs == RING_TIMEOUT_SEC) begin m_mode = 0; m_missed = 1; end
      end
      if (m_mode == 1) m_ring_cycles++;
    end else begin
      if (!en || stop_e) m_mode = 0;
      else if (tick) begin
        m_secs++;
        if (m_secs == SNOOZE_SEC) begin m_mode = 1; m_secs = 0; m_ring_cycles = 0; end
      end
    end
`ifdef ALARM_LED_BLINK_EN
    if (m_mode == 0) m_led = 0;
    else if (old_mode != 0 && tick) m_led = !m_led;
`else
    m_led = (m_mode == 1) || m_missed;
    if (old_mode < 0) m_led = 0;
`endif
  endtask

  task automatic check_model();
    bit exp_buzz;
    exp_buzz = (m_mode == 1) && (((m_ring_cycles / TONE_DIV) % 2) == 1);
    chk("ringing",  o_ringing,  m_mode == 1);
    chk("snoozing", o_snoozing, m_mode == 2);
    chk("missed",   o_missed,   m_missed);
    chk("buzzer",   o_buzzer,   exp_buzz);
    chk("led",      o_led,      m_led);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) model_reset();
      else model_update();
      #1;
      check_model();
    end
  endtask

  task automatic do_tick();
    tick = 1; step(1); tick = 0; step(1);
  endtask

  task automatic do_match();
    match = 1; step(1); match = 0;
  endtask

  task automatic press_snooze();
    snz = 1; step(1); snz = 0; step(1);
  endtask

  initial begin
    model_reset();
    step(3);
    chk("reset_ringing", o_ringing, 1'b0);
    chk("reset_buzzer",  o_buzzer,  1'b0);
    chk("reset_led",     o_led,     1'b0);
    rst = 0;
    en  = 1;

    // Ring and tone cadence
    do_match();
    chk("ring_after_match", o_ringing, 1'b1);
    chk("buzz_starts_low",  o_buzzer,  1'b0);
    step(18);

    // Three snoozes allowed, fourth ignored
    for (int k = 0; k < MAX_SNOOZES; k++) begin
      snz = 1; step(1);
      chk("snooze_entered", o_snoozing, 1'b1);
      chk("snooze_buzz_off", o_buzzer, 1'b0);
      snz = 0; step(1);
      for (int t = 0; t < SNOOZE_SEC; t++) do_tick();
      chk("ring_after_snooze", o_ringing, 1'b1);
    end
    press_snooze();
    chk("fourth_snooze_ignored", o_ringing, 1'b1);

    // Timeout marks missed; stop clears it
    for (int t = 0; t < RING_TIMEOUT_SEC - 1; t++) do_tick();
    chk("ring_before_timeout", o_ringing, 1'b1);
    do_tick();
    chk("idle_after_timeout", o_ringing, 1'b0);
    chk("missed_set", o_missed, 1'b1);
    stp = 1; step(1); stp = 0;
    chk("missed_cleared", o_missed, 1'b0);
    step(1);

    // Simultaneous stop+snooze; held stop does not re-act
    do_match();
    stp = 1; snz = 1; step(1);
    chk("stop_beats_snooze", o_snoozing, 1'b0);
    chk("stop_to_idle", o_ringing, 1'b0);
    snz = 0; step(2);
    do_match();
    step(3);
    chk("held_stop_no_effect", o_ringing, 1'b1);
    stp = 0; step(1);

    // Stop at the same cycle as the timeout tick: no missed
    for (int t = 0; t < RING_TIMEOUT_SEC - 1; t++) do_tick();
    tick = 1; stp = 1; step(1); tick = 0; stp = 0;
    chk("stop_at_timeout_no_missed", o_missed, 1'b0);
    step(1);

    // Disarm while snoozing; match ignored when disarmed
    do_match();
    press_snooze();
    en = 0; step(1);
    chk("disarm_to_idle", o_snoozing, 1'b0);
    do_match();
    step(1);
    chk("disarmed_match_ignored", o_ringing, 1'b0);
    en = 1;

    // Asynchronous reset mid-ringing, then fresh timeout
    do_match();
    do_tick(); do_tick();
    step(2);
    #3 rst = 1;
    #1;
    model_reset();
    chk("async_rst_ringing", o_ringing, 1'b0);
    chk("async_rst_buzzer",  o_buzzer,  1'b0);
    chk("async_rst_led",     o_led,     1'b0);
    step(2);
    rst = 0;
    do_match();
    for (int t = 0; t < RING_TIMEOUT_SEC - 1; t++) do_tick();
    chk("fresh_timeout_count", o_ringing, 1'b1);
    do_tick();
    chk("fresh_timeout_missed", o_missed, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick  = ($urandom_range(0, 3) == 0);
      match = ($urandom_range(0, 29) == 0);
      en    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0)  snz = ~snz;
      if ($urandom_range(0, 39) == 0) stp = ~stp;
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
